// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: drives main/side lamps from traffic-timer expiry flags, with a watchdog fault state.
// Optional ALL_RED_EN macro inserts all-red clearance states (AR1, AR2) between the yellow and green phases.
module traffic_light_ctrl #(
  parameter int TIMEOUT    = 64,
  parameter int FLASH_DIV  = 4,
  parameter int ALLRED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car,
  input  logic       tMG,
  input  logic       tMY,
  input  logic       tSG,
  input  logic       tSY,
  output logic       start,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic [2:0] state,
  output logic       fault
);

  // Timer handshake: start pulses for one cycle on every timed-state entry;
  // the timer's level flags are honoured only from the cycle after that pulse.
  typedef enum logic [2:0] {
    S_MGRN  = 3'd0,
    S_MYEL  = 3'd1,
    S_SGRN  = 3'd2,
    S_SYEL  = 3'd3,
    S_AR1   = 3'd4,
    S_AR2   = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  if (TIMEOUT < 8 || TIMEOUT > 65535 || FLASH_DIV < 1 || ALLRED_CYC < 1) begin : g_param_check
    $error("traffic_light_ctrl: parameter out of range");
  end

  state_t      cur;
  state_t      nxt;
  logic        adv;
  logic        cnt;
  logic [15:0] wd;
  logic [15:0] flash_cnt;
`ifdef ALL_RED_EN
  logic [15:0] ar_cnt;
`endif

  assign state = cur;

  // Lamp order: {MR, MY, MG, SR, SY, SG}
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      S_MGRN:  return 6'b001100;
      S_MYEL:  return 6'b010100;
      S_SGRN:  return 6'b100001;
      S_SYEL:  return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  always_comb begin
    adv = 1'b0;
    cnt = 1'b0;
    nxt = cur;
    case (cur)
      S_MGRN: begin
        cnt = !tMG;
        adv = !start && tMG && car;
        nxt = S_MYEL;
      end
      S_MYEL: begin
        cnt = 1'b1;
        adv = !start && tMY;
`ifdef ALL_RED_EN
        nxt = S_AR1;
`else
        nxt = S_SGRN;
`endif
      end
      S_SGRN: begin
        cnt = 1'b1;
        adv = !start && (tSG || !car);
        nxt = S_SYEL;
      end
      S_SYEL: begin
        cnt = 1'b1;
        adv = !start && tSY;
`ifdef ALL_RED_EN
        nxt = S_AR2;
`else
        nxt = S_MGRN;
`endif
      end
`ifdef ALL_RED_EN
      S_AR1: begin
        adv = (ar_cnt == 16'(ALLRED_CYC - 1));
        nxt = S_SGRN;
      end
      S_AR2: begin
        adv = (ar_cnt == 16'(ALLRED_CYC - 1));
        nxt = S_MGRN;
      end
`endif
      default: begin
        adv = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur                      <= S_MGRN;
      {MR, MY, MG, SR, SY, SG} <= 6'b001100;
      start                    <= 1'b1;
      fault                    <= 1'b0;
      wd                       <= '0;
      flash_cnt                <= '0;
`ifdef ALL_RED_EN
      ar_cnt                   <= '0;
`endif
    end else begin
      start <= 1'b0;
      if (cur == S_FAULT) begin
        if (flash_cnt == 16'(FLASH_DIV - 1)) begin
          flash_cnt <= '0;
          MR        <= !MR;
          SR        <= !SR;
        end else begin
          flash_cnt <= flash_cnt + 16'd1;
        end
      end else if (adv) begin
        // The expected flag takes priority over a watchdog expiring in the same cycle.
        cur                      <= nxt;
        {MR, MY, MG, SR, SY, SG} <= lamps_of(nxt);
        start                    <= (nxt != S_AR1) && (nxt != S_AR2);
        wd                       <= '0;
`ifdef ALL_RED_EN
        ar_cnt                   <= '0;
`endif
      end else if (cnt) begin
        if (wd == 16'(TIMEOUT - 1)) begin
          cur                      <= S_FAULT;
          {MR, MY, MG, SR, SY, SG} <= 6'b100100;
          fault                    <= 1'b1;
          flash_cnt                <= '0;
        end else begin
          wd <= wd + 16'd1;
        end
      end
`ifdef ALL_RED_EN
      else if (cur == S_AR1 || cur == S_AR2) begin
        ar_cnt <= ar_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl (TIMEOUT=16, FLASH_DIV=4, ALLRED_CYC=2).
// Builds with or without ALL_RED_EN; the all-red expectations switch with the macro.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       car = 1'b0;
  logic       tMG = 1'b0;
  logic       tMY = 1'b0;
  logic       tSG = 1'b0;
  logic       tSY = 1'b0;
  logic       start;
  logic       MR, MY, MG, SR, SY, SG;
  logic [2:0] state;
  logic       fault;
  logic [5:0] lamps;

  int n_tests = 0;
  int n_fail  = 0;

  assign lamps = {MR, MY, MG, SR, SY, SG};

  traffic_light_ctrl #(
    .TIMEOUT   (16),
    .FLASH_DIV (4),
    .ALLRED_CYC(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .car  (car),
    .tMG  (tMG),
    .tMY  (tMY),
    .tSG  (tSG),
    .tSY  (tSY),
    .start(start),
    .MR   (MR),
    .MY   (MY),
    .MG   (MG),
    .SR   (SR),
    .SY   (SY),
    .SG   (SG),
    .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks through one all-red state when the feature is built in; no-op otherwise.
  task automatic pass_ar(input logic [2:0] ar_st);
`ifdef ALL_RED_EN
    chk("ar_entry_state", 16'(state), 16'(ar_st));
    chk("ar_lamps", 16'(lamps), 16'b100100);
    chk("ar_no_start", 16'(start), 16'd0);
    step();
    chk("ar_hold_state", 16'(state), 16'(ar_st));
    step();
`else
    chk("no_ar_state", 16'(state == 3'd4 || state == 3'd5), 16'd0);
`endif
  endtask

  initial begin
    int bad;
    // Reset held 5 cycles
    repeat (5) step();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_lamps", 16'(lamps), 16'b001100);
    chk("rst_start", 16'(start), 16'd1);
    chk("rst_fault", 16'(fault), 16'd0);
    rst = 1'b0;
    step();
    chk("start_drop", 16'(start), 16'd0);
    chk("mgrn_hold", 16'(state), 16'd0);
    repeat (2) step();

    // Main green -> main yellow
    car = 1'b1; tMG = 1'b1;
    step();
    chk("myel_state", 16'(state), 16'd1);
    chk("myel_lamps", 16'(lamps), 16'b010100);
    chk("myel_start", 16'(start), 16'd1);
    tMG = 1'b0; tMY = 1'b1;
    step();
    chk("myel_flag_ignored", 16'(state), 16'd1);
    chk("myel_start_end", 16'(start), 16'd0);
    step();
    tMY = 1'b0;
    pass_ar(3'd4);
    chk("sgrn_state", 16'(state), 16'd2);
    chk("sgrn_lamps", 16'(lamps), 16'b100001);
    chk("sgrn_start", 16'(start), 16'd1);

    // Early side-green termination with a stray main flag present
    car = 1'b0; tMG = 1'b1;
    step();
    chk("sgrn_start_cycle", 16'(state), 16'd2);
    step();
    chk("syel_state", 16'(state), 16'd3);
    chk("syel_lamps", 16'(lamps), 16'b100010);
    chk("syel_start", 16'(start), 16'd1);
    tSY = 1'b1;
    step();
    chk("syel_flag_ignored", 16'(state), 16'd3);
    step();
    tSY = 1'b0;
    pass_ar(3'd5);
    chk("back_mgrn", 16'(state), 16'd0);
    chk("back_mgrn_lamps", 16'(lamps), 16'b001100);
    chk("back_mgrn_start", 16'(start), 16'd1);

    // No car: main green held without watchdog counting
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (state !== 3'd0 || start !== 1'b0 || fault !== 1'b0) bad++;
    end
    chk("mgrn_wait_100", 16'(bad), 16'd0);

    // Watchdog: tMY never arrives
    car = 1'b1;
    step();
    chk("wd_myel_entry", 16'(state), 16'd1);
    tMG = 1'b0;
    repeat (15) step();
    chk("wd_before", 16'(state), 16'd1);
    chk("wd_before_fault", 16'(fault), 16'd0);
    tMY = 1'b0;
    step();
    chk("wd_fault_state", 16'(state), 16'd7);
    chk("wd_fault_flag", 16'(fault), 16'd1);
    chk("wd_fault_lamps", 16'(lamps), 16'b100100);
    chk("wd_fault_start", 16'(start), 16'd0);
    tMY = 1'b1; tSG = 1'b1; tSY = 1'b1;
    repeat (3) step();
    chk("flash_on_end", 16'(lamps), 16'b100100);
    step();
    chk("flash_off", 16'(lamps), 16'b000000);
    repeat (3) step();
    chk("flash_off_end", 16'(lamps), 16'b000000);
    step();
    chk("flash_on_again", 16'(lamps), 16'b100100);
    chk("fault_sticky", 16'(state), 16'd7);

    // Asynchronous reset out of FAULT
    tMY = 1'b0; tSG = 1'b0; tSY = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 16'(state), 16'd0);
    chk("async_rst_fault", 16'(fault), 16'd0);
    chk("async_rst_start", 16'(start), 16'd1);
    chk("async_rst_lamps", 16'(lamps), 16'b001100);
    step();
    rst = 1'b0;
    step();

    // Flag arriving on the same cycle the watchdog expires wins
    car = 1'b1; tMG = 1'b1;
    step();
    chk("race_myel", 16'(state), 16'd1);
    tMG = 1'b0;
    repeat (15) step();
    tMY = 1'b1;
    step();
    tMY = 1'b0;
    chk("race_no_fault", 16'(fault), 16'd0);
    pass_ar(3'd4);
    chk("race_sgrn", 16'(state), 16'd2);
    chk("race_sgrn_start", 16'(start), 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Controller end of the traffic-timer interface: issues `start` to the traffic timer and consumes its expiry flags `tMG`/`tMY`/`tSG`/`tSY`.
- Drives main-road and side-road lamps through a Main-Green → Main-Yellow → Side-Green → Side-Yellow cycle.
- Main green is held until a side-road car is present.
- A watchdog forces a flashing-red fault state if the timer stops responding.

Parameters:
- TIMEOUT, 64, cycles allowed in any timed state without the expected expiry flag before fault; 8..65535.
- FLASH_DIV, 4, cycles per half-period of the fault flash; ≥1.
- ALLRED_CYC, 2, all-red clearance length in cycles; used only with ALL_RED_EN; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- car  in  1  side-road vehicle sensor, synchronous level.
- tMG  in  1  timer: main-green interval elapsed, level.
- tMY  in  1  timer: main-yellow interval elapsed, level.
- tSG  in  1  timer: side-green interval elapsed, level.
- tSY  in  1  timer: side-yellow interval elapsed, level.
- start  out  1  timer restart, one-cycle pulse on each state entry.
- MR, MY, MG  out  1 each  main-road lamps, one-hot except in fault.
- SR, SY, SG  out  1 each  side-road lamps, one-hot except in fault.
- state  out  3  encoding: MGRN=0, MYEL=1, SGRN=2, SYEL=3, AR1=4, AR2=5, FAULT=7.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (async assert), all outputs registered:
  - state=MGRN, MG=1, SR=1, other lamps 0.
  - start=1, fault=0, watchdog=0.
- First clk edge after release: start=0.
- `start` rules:
  - Asserted for exactly one cycle in the first cycle of every timed-state entry.
  - Timer flags are ignored in that cycle and evaluated from the following cycle onward.
- Transitions, evaluated each clk in the current state's non-start cycles:
  - MGRN → MYEL when tMG=1 and car=1.
  - MGRN with tMG=1 and car=0: remain, no restart.
  - MYEL → SGRN when tMY=1 (→ AR1 if ALL_RED_EN).
  - SGRN → SYEL when tSG=1, or when car=0 and at least 1 cycle has elapsed since entry (early termination).
  - SYEL → MGRN when tSY=1 (→ AR2 if ALL_RED_EN).
  - Flags for non-current states are ignored.
- Lamps:
  - MGRN: MG, SR.
  - MYEL: MY, SR.
  - SGRN: MR, SG.
  - SYEL: MR, SY.
  - AR1/AR2: MR, SR.
  - Lamps change on the same edge as the state register.
- Watchdog:
  - 16-bit counter, cleared on every state entry; increments each cycle in MYEL, SGRN, SYEL, and in MGRN while tMG=0.
  - Reaching TIMEOUT → FAULT on the next edge.
  - MGRN waiting with tMG=1, car=0 does not count.
- FAULT:
  - MR=SR toggle together every FLASH_DIV cycles, starting at 1; all other lamps 0.
  - fault=1, start=0.
  - Exit only via rst.
- Simultaneous events:
  - Watchdog reaching TIMEOUT in the same cycle as the expected flag: the flag wins (normal transition).
  - Multiple flags asserted: only the current state's flag counts.
- Reset mid-cycle: immediate return to reset values regardless of state, including FAULT.

Optional Feature:
- Macro: ALL_RED_EN.
- Defined:
  - AR1 is inserted between MYEL and SGRN, and AR2 between SYEL and MGRN.
  - Each lasts ALLRED_CYC cycles, counted internally.
  - No start pulse on AR entry; start pulses on exit into the next timed state.
  - Watchdog is not active in AR states.
- Undefined:
  - AR states are unreachable; state values 4/5 are never produced.
  - The AR counter is not synthesized.

Test Plan:
- Reset held 5 cycles, then released → state=0, MG=1, SR=1 during reset; start=1 until the first edge after release, then 0.
- car=1; tMG pulsed 3 cycles after release → next edge state=1, MY=1, start=1 for one cycle; tMY → state=2, SG=1, MR=1.
- car=0 with tMG=1 held → state stays 0 for ≥100 cycles, no start pulse, fault=0.
- In SGRN, drop car=0 → SYEL two edges after entry; tSY → state=0, start pulses.
- TIMEOUT=16, never assert tMY in MYEL → state=7 exactly 16 cycles after entry; fault=1; MR=SR toggle every 4 cycles; rst clears to state 0.
- With ALL_RED_EN, ALLRED_CYC=2: tMY → state=4, MR=SR=1 for 2 cycles, then state=2 with start=1 on that entry cycle.
